// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared encodings and parameter defaults for seq_detect_scheduler
// Build option SEQDET_OVERLAP_EN selects overlapping "11" detection.
package seqdet_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } fsm_state_t;

  typedef enum logic {
    DET_A = 1'b0,
    DET_B = 1'b1
  } det_state_t;

endpackage

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - Mealy "11" detector, z = (state==B && w)
// SEQDET_OVERLAP_EN keeps the detector in B after a hit so runs of ones overlap.
module seq_det_core
  import seqdet_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic w,
  output logic z
);

  det_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_A;
    end else if (en) begin
      case (state_q)
        DET_A: state_d = w ? DET_B : DET_A;
        DET_B: begin
`ifdef SEQDET_OVERLAP_EN
          state_d = w ? DET_B : DET_A;
`else
          state_d = DET_A;
`endif
        end
        default: state_d = DET_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DET_A;
    else     state_q <= state_d;
  end

  assign z = (state_q == DET_B) && w;

endmodule

// File: rtl/seq_detect_scheduler.sv
// rtl/seq_detect_scheduler.sv - round-robin grant, W-cycle LSB-first "11" scan, one-cycle result strobe
// Detector overlap behaviour is selected by SEQDET_OVERLAP_EN (see seq_det_core).
module seq_detect_scheduler
  import seqdet_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*W-1:0]       data,
  output logic [N_CH-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(N_CH)-1:0] done_id,
  output logic [$clog2(W)-1:0]    match_cnt,
  output logic                    z_mon
);

  localparam int CW = $clog2(N_CH);
  localparam int IW = $clog2(W);
  localparam logic [N_CH-1:0] GNT_ONE  = 1;
  localparam logic [IW-1:0]   LAST_BIT = IW'(W - 1);

  fsm_state_t      state_q, state_d;
  logic [N_CH-1:0] gnt_q, gnt_d;
  logic [CW-1:0]   done_id_q, done_id_d;
  logic [IW-1:0]   match_cnt_q, match_cnt_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    data_q, data_d;

  logic          win_found;
  logic [CW-1:0] win_id;
  logic [CW-1:0] cand;
  logic          det_clr, det_en, det_z;

  // First requester at or after ptr; CW-bit addition wraps since N_CH is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = ptr_q + CW'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    data_d      = data_q;
    det_clr     = 1'b0;
    det_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d     = ST_SHIFT;
          gnt_d       = GNT_ONE << win_id;
          done_id_d   = win_id;
          match_cnt_d = '0;
          ptr_d       = win_id + CW'(1);
          idx_d       = '0;
          data_d      = data[W*win_id +: W];
          det_clr     = 1'b1;
        end
      end
      ST_SHIFT: begin
        det_en = 1'b1;
        if (det_z && (match_cnt_q != LAST_BIT)) match_cnt_d = match_cnt_q + IW'(1);
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_BIT) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
    end
  end

  seq_det_core u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (det_en),
    .w   (data_q[idx_q]),
    .z   (det_z)
  );

  assign gnt       = gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_REPORT);
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;
  assign z_mon     = (state_q == ST_SHIFT) ? det_z : 1'b0;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb/tb_seq_detect_scheduler.sv - scoreboard bench for seq_detect_scheduler
// Expected counts follow SEQDET_OVERLAP_EN when the bench is built with it.
module tb_seq_detect_scheduler;

  localparam int N_CH = 4;
  localparam int W    = 8;
`ifdef SEQDET_OVERLAP_EN
  localparam int CNT_FF = 7;
  localparam int CNT_0F = 3;
`else
  localparam int CNT_FF = 4;
  localparam int CNT_0F = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   req;
  logic [N_CH*W-1:0] data;
  logic [N_CH-1:0]   gnt;
  logic              busy, done, z_mon;
  logic [1:0]        done_id;
  logic [2:0]        match_cnt;

  typedef struct {
    int id;
    int cnt;
    int at_edge;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   finished = 1'b0;

  seq_detect_scheduler #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt),
    .z_mon     (z_mon)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input int cnt, input int t);
    exp_t e;
    e.id = id;
    e.cnt = cnt;
    e.at_edge = t + W;
    exp_q.push_back(e);
  endtask

  // Single-channel transaction: grant at edge t, done seen after edge t+W, idle after t+W+1.
  task automatic run_txn(input int ch, input logic [W-1:0] word, input int cnt);
    @(negedge clk);
    data[ch*W +: W] = word;
    req = 4'b0001 << ch;
    @(posedge clk);
    #1;
    chk("grant", gnt, 1 << ch);
    chk("busy_in_shift", busy, 1);
    push_exp(ch, cnt, cyc);
    req = '0;
    repeat (W + 1) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot0", $onehot0(gnt), 1);
      if (!busy) chk("z_mon_idle", z_mon, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_id", done_id, mon_e.id);
          chk("match_cnt", match_cnt, mon_e.cnt);
          chk("done_cycle", cyc, mon_e.at_edge);
        end
      end
    end
  end

  initial begin
    #50000;
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst = 1'b1;
    req = '0;
    data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_z_mon", z_mon, 0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(0, 8'hFF, CNT_FF);
    run_txn(1, 8'h36, 2);
    run_txn(2, 8'hAA, 0);
    run_txn(3, 8'h00, 0);

    // All requesters held: expect 0,1,2,3,0 with one idle cycle between transactions.
    @(negedge clk);
    data = {8'h0F, 8'hAA, 8'h36, 8'hFF};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      @(posedge clk);
      #1;
      chk("rr_grant", gnt, 1 << (g % 4));
      case (g % 4)
        0: push_exp(0, CNT_FF, cyc);
        1: push_exp(1, 2, cyc);
        2: push_exp(2, 0, cyc);
        default: push_exp(3, CNT_0F, cyc);
      endcase
      if (g == 4) req = '0;
      repeat (W + 1) @(posedge clk);
    end

    // Inputs changed after grant must not affect the result.
    @(negedge clk);
    data[W +: W] = 8'h36;
    req = 4'b0010;
    @(posedge clk);
    #1;
    chk("late_change_grant", gnt, 4'b0010);
    push_exp(1, 2, cyc);
    req = '0;
    data = '1;
    repeat (3) @(posedge clk);
    data = '0;
    repeat (W - 2) @(posedge clk);
    #1;
    chk("late_change_idle", busy, 0);

    // Reset in the middle of a scan: nothing reported, then a clean grant.
    @(negedge clk);
    data[0 +: W] = 8'hFF;
    req = 4'b0001;
    @(posedge clk);
    #1;
    chk("abort_grant", gnt, 1);
    req = '0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_done_id", done_id, 0);
    chk("async_rst_match_cnt", match_cnt, 0);
    chk("async_rst_z_mon", z_mon, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);
    run_txn(2, 8'h36, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    finished = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of requesters, power of two, at least 2.
REQ-002 SHALL have parameter W, default 8: word width scanned per transaction.
REQ-003 Ports (clock and reset first):
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  N_CH  per-channel request, level.
- data  input  N_CH*W  channel i word at data[W*i+W-1:W*i].
- gnt  output  N_CH  one-hot grant.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle result strobe.
- done_id  output  log2(N_CH)  channel index of the result.
- match_cnt  output  log2(W)  count of "11" detections.
- z_mon  output  1  live detector output while shifting, else 0.

Function
REQ-004 SHALL implement FSM IDLE -> SHIFT -> REPORT -> IDLE.
REQ-005 In IDLE with req != 0 at edge t, SHALL select the winner by round-robin and set gnt, busy and done_id to that channel. At the same edge it SHALL latch data for that channel, clear match_cnt and the detector, zero the bit index, and enter SHIFT.
REQ-006 Round-robin SHALL grant the first requesting channel at or after ptr, wrapping. After granting channel i, ptr SHALL become (i+1) mod N_CH.
REQ-007 SHIFT SHALL feed one latched bit per cycle, LSB first, for exactly W cycles into a Mealy "11" detector, which starts in state A.
REQ-008 On each SHIFT edge where detector output z=1, match_cnt SHALL increment, saturating at W-1.
REQ-009 After the W-th bit, the FSM SHALL enter REPORT. done SHALL be 1 for exactly that cycle, with match_cnt and done_id valid.
REQ-010 The edge after REPORT SHALL return the FSM to IDLE and clear gnt, busy and done.
REQ-011 match_cnt and done_id SHALL hold their values until the next grant.
REQ-012 Latency SHALL be fixed: req seen at edge t gives done high in cycle t+W+1. The earliest next grant SHALL be at edge t+W+2.
REQ-013 Changes to req or data after grant SHALL be ignored; the transaction always completes.
REQ-014 Requests arriving during SHIFT or REPORT SHALL wait; none is lost while its req stays high.
REQ-015 gnt SHALL be one-hot or zero at all times. busy SHALL be 1 in SHIFT and REPORT.

Reset
REQ-016 When rst is asserted, asynchronously and at any point including mid-SHIFT, the block SHALL:
- set state to IDLE, detector to A and ptr to 0;
- drive gnt, busy, done, done_id, match_cnt and z_mon to 0;
- discard any partial transaction with no done strobe.

Configuration
REQ-017 With macro SEQDET_OVERLAP_EN defined, the detector SHALL stay in B after a detection, so overlapping matches count: "111" gives 2.
REQ-018 Without SEQDET_OVERLAP_EN, the detector SHALL return to A after each detection, so matches are non-overlapping: "111" gives 1.

Structure
REQ-019 Package seqdet_pkg SHALL hold:
- FSM state encoding (IDLE, SHIFT, REPORT);
- detector state encoding (A, B);
- defaults for N_CH and W.
REQ-020 The detector SHALL be sub-module seq_det_core, with ports clk, rst, clr, en, w and z. It SHALL be a Mealy machine with z = (state==B && w==1).

Verification
REQ-021 Channel 0, data 0xFF: overlap build gives match_cnt=7; non-overlap build gives match_cnt=4; done in cycle t+9 in both.
REQ-022 Channel 1, data 0x36 (LSB-first 0,1,1,0,1,1,0,0): match_cnt=2 and done_id=1 in both builds. Data 0xAA and 0x00 give 0.
REQ-023 req=4'b1111 held high: grants SHALL be channels 0,1,2,3,0, each one cycle after the previous REPORT.
REQ-024 req toggled to 0 and data changed during SHIFT: the result SHALL be computed from the word latched at grant, and done still fires.
REQ-025 rst pulse at SHIFT bit 4: all outputs are 0 immediately and no done strobe. Then with req=4'b0100, channel 2 is granted and its result is correct.
